// File: rtl/alu_exec_if.sv
// Request/response bundle between a requester and the alu_exec iterative ALU.
interface alu_exec_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       ALUop;
   logic [3:0]       Funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             err;

   modport master (output in_valid, ALUop, Funct, a, b, out_ready,
                   input  in_ready, out_valid, result, zero, err);
   modport slave  (input  in_valid, ALUop, Funct, a, b, out_ready,
                   output in_ready, out_valid, result, zero, err);
endinterface

// File: rtl/alu_exec.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial shifts and a shift-add multiplier,
// with a valid/ready request side and a result held until consumed.
module alu_exec #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus
);
   localparam int unsigned CNTW = SHW + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
   } op_e;

   state_e           state_q, state_d;
   op_e              kind_q, kind_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   op_e              dec_op;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] shift_nxt;
   logic [WIDTH-1:0] acc_nxt;
   logic [SHW-1:0]   shamt;

   assign shamt = bus.b[SHW-1:0];

   // Operation decode from ALUop/Funct
   always_comb begin
      dec_op = OP_ILL;
      case (bus.ALUop)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            case (bus.Funct)
               4'b0000: dec_op = OP_ADD;
               4'b1000: dec_op = OP_SUB;
               4'b0111: dec_op = OP_AND;
               4'b0110: dec_op = OP_OR;
               4'b0100: dec_op = OP_XOR;
               4'b0001: dec_op = OP_SLL;
               4'b0101: dec_op = OP_SRL;
               4'b1101: dec_op = OP_SRA;
               4'b1111: dec_op = OP_MUL;
               default: dec_op = OP_ILL;
            endcase
         end
         default: begin
            case (bus.Funct[2:0])
               3'b000:  dec_op = OP_ADD;
               3'b111:  dec_op = OP_AND;
               3'b110:  dec_op = OP_OR;
               3'b100:  dec_op = OP_XOR;
               3'b001:  dec_op = OP_SLL;
               3'b101:  dec_op = bus.Funct[3] ? OP_SRA : OP_SRL;
               default: dec_op = OP_ILL;
            endcase
         end
      endcase
   end

   // Single-cycle results; illegal ops yield zero
   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD:  alu_res = bus.a + bus.b;
         OP_SUB:  alu_res = bus.a - bus.b;
         OP_AND:  alu_res = bus.a & bus.b;
         OP_OR:   alu_res = bus.a | bus.b;
         OP_XOR:  alu_res = bus.a ^ bus.b;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      shift_nxt = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      if (kind_q == OP_SLL) begin
         shift_nxt = {work_q[WIDTH-2:0], 1'b0};
      end else if (kind_q == OP_SRL) begin
         shift_nxt = {1'b0, work_q[WIDTH-1:1]};
      end
      acc_nxt = work_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      work_d   = work_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               kind_d = dec_op;
               err_d  = (dec_op == OP_ILL);
               case (dec_op)
                  OP_SLL, OP_SRL, OP_SRA: begin
                     if (shamt == '0) begin
                        result_d = bus.a;
                        zero_d   = (bus.a == '0);
                        state_d  = DONE;
                     end else begin
                        work_d  = bus.a;
                        cnt_d   = CNTW'(shamt);
                        state_d = SHIFT;
                     end
                  end
                  OP_MUL: begin
                     work_d   = '0;
                     mcand_d  = bus.a;
                     mplier_d = bus.b;
                     cnt_d    = CNTW'(WIDTH);
                     state_d  = MUL;
                  end
                  default: begin
                     result_d = alu_res;
                     zero_d   = (alu_res == '0);
                     state_d  = DONE;
                  end
               endcase
            end
         end
         SHIFT: begin
            work_d = shift_nxt;
            cnt_d  = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               result_d = shift_nxt;
               zero_d   = (shift_nxt == '0);
               state_d  = DONE;
            end
         end
         MUL: begin
            work_d   = acc_nxt;
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               result_d = acc_nxt;
               zero_d   = (acc_nxt == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         kind_q   <= OP_ADD;
         work_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         work_q   <= work_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && rst;
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.err       = err_q;
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data path width, legal 8..64.
REQ-002 SHALL have parameter SHW, default 5: shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port ALUop  input  2  operation class.
REQ-008 SHALL have port Funct  input  4  function field.
REQ-009 SHALL have port a  input  WIDTH  operand A.
REQ-010 SHALL have port b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port result  output  WIDTH  registered result.
REQ-014 SHALL have port zero  output  1  registered (result == 0).
REQ-015 SHALL have port err  output  1  registered; set when the accepted op was illegal.

Function
REQ-016 SHALL decode ALUop 00 -> ADD and ALUop 01 -> SUB, ignoring Funct.
REQ-017 SHALL decode ALUop 10 on Funct: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, 1111 MUL; every other code is illegal.
REQ-018 SHALL decode ALUop 11 on Funct[2:0]: 000 ADD, 111 AND, 110 OR, 100 XOR, 001 SLL, 101 SRL if Funct[3]=0 else SRA; 010, 011 illegal.
REQ-019 SHALL accept a request only on a clock edge where in_valid=1 and in_ready=1, latching ALUop, Funct, a and b; later operand changes SHALL have no effect.
REQ-020 SHALL drive in_ready = 1 only in state IDLE with rst=1.
REQ-021 SHALL implement FSM states IDLE, SHIFT, MUL and DONE.
REQ-022 IDLE accept -> DONE for ADD, SUB, AND, OR, XOR, illegal ops and shifts with amount 0; -> SHIFT for shifts with amount > 0; -> MUL for MUL.
REQ-023 SHIFT SHALL move the working value by one bit per cycle (SRA replicates the MSB) and SHALL go to DONE after exactly shamt cycles.
REQ-024 MUL SHALL use shift-add, one multiplier bit per cycle, and SHALL go to DONE after exactly WIDTH cycles; result SHALL be the low WIDTH bits of a*b (unsigned).
REQ-025 ADD and SUB SHALL wrap modulo 2^WIDTH with no overflow flag.
REQ-026 Latency: with acceptance at edge T, out_valid SHALL rise at edge T+1 for single-cycle ops, T+1+shamt for shifts and T+1+WIDTH for MUL.
REQ-027 In DONE, out_valid=1 and result, zero and err SHALL stay stable until an edge with out_ready=1; that edge -> IDLE and out_valid=0.
REQ-028 No new request SHALL be accepted on the same edge a result is consumed (in_ready=0 in DONE).
REQ-029 An illegal op SHALL give result=0, zero=1 and err=1 with single-cycle latency; err SHALL clear on the next accepted legal op.
REQ-030 in_valid while busy SHALL be ignored and no request SHALL be lost or queued.

Reset
REQ-031 On any edge with rst=0: state IDLE, out_valid=0, result=0, zero=0, err=0; in_ready SHALL be 0 while rst=0.
REQ-032 Reset during SHIFT, MUL or DONE SHALL abort the operation with no out_valid pulse; in_ready=1 on the first edge after rst returns to 1.

Verification
REQ-033 WIDTH=32, ALUop=10, Funct=1000, a=5, b=5 -> out_valid one cycle after accept, result=0, zero=1, err=0.
REQ-034 ALUop=10, Funct=1101, a=0x80000000, b=4 -> out_valid 5 cycles after accept, result=0xF8000000, in_ready=0 throughout.
REQ-035 ALUop=10, Funct=1111, a=0xFFFFFFFF, b=3 -> out_valid 33 cycles after accept, result=0xFFFFFFFD.
REQ-036 ALUop=11, Funct=x010 -> err=1, result=0, zero=1; then ADD 1+1 -> err=0, result=2.
REQ-037 out_ready held 0 for 10 cycles in DONE, with a and b toggling -> result stable, in_valid ignored, IDLE after out_ready=1.
REQ-038 rst=0 for one edge mid-MUL -> out_valid never rises, in_ready=1 next edge; WIDTH=8 rerun of REQ-035 -> result=0xFD after 9 cycles.
